// File: rtl/hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: load-use, EX redirects and data-memory waits,
// with a memory-wait timeout and saturating stall/flush event counters.
module hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [4:0]       i_id_rs1,
    input  logic [4:0]       i_id_rs2,
    input  logic             i_id_rs1_used,
    input  logic             i_id_rs2_used,
    input  logic [4:0]       i_ex_rd,
    input  logic             i_ex_is_load,
    input  logic             i_ex_regwen,
    input  logic             i_ex_redirect,
    input  logic             i_mem_req,
    input  logic             i_mem_ready,
    output logic             o_pc_en,
    output logic             o_stall_12,
    output logic             o_flush_12,
    output logic             o_stall_23,
    output logic             o_flush_23,
    output logic             o_stall_34,
    output logic             o_flush_45,
    output logic             o_mem_err,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    typedef enum logic {StRun, StWait} state_e;

    localparam logic [7:0] WaitLast = 8'(MEM_TIMEOUT - 1);

    state_e           r_state;
    state_e           w_state_next;
    logic [7:0]       r_wait_cnt;
    logic             r_mem_err;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic w_load_use;
    logic w_timeout;
    logic w_mem_wait;
    logic w_flush_evt;

    assign w_load_use = i_ex_is_load & i_ex_regwen & (i_ex_rd != 5'd0) &
                        ((i_id_rs1_used & (i_id_rs1 == i_ex_rd)) |
                         (i_id_rs2_used & (i_id_rs2 == i_ex_rd)));

    // A timeout releases the access in the same cycle, exactly as a ready would.
    assign w_timeout   = (r_state == StWait) & (r_wait_cnt == WaitLast) & ~i_mem_ready;
    assign w_mem_wait  = i_mem_req & ~i_mem_ready & ~w_timeout;
    assign w_flush_evt = ~w_mem_wait & i_ex_redirect;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= StRun;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StRun:   if (w_mem_wait) w_state_next = StWait;
            StWait:  if (i_mem_ready || w_timeout) w_state_next = StRun;
            default: w_state_next = StRun;
        endcase
    end

    always_comb begin
        o_pc_en    = 1'b1;
        o_stall_12 = 1'b0;
        o_flush_12 = 1'b0;
        o_stall_23 = 1'b0;
        o_flush_23 = 1'b0;
        o_stall_34 = 1'b0;
        o_flush_45 = 1'b0;
        if (w_mem_wait) begin
            // EX and ID are held, so a pending redirect or load-use re-presents after release.
            o_pc_en    = 1'b0;
            o_stall_12 = 1'b1;
            o_stall_23 = 1'b1;
            o_stall_34 = 1'b1;
            o_flush_45 = 1'b1;
        end else if (i_ex_redirect) begin
            o_flush_12 = 1'b1;
            o_flush_23 = 1'b1;
        end else if (w_load_use) begin
            o_pc_en    = 1'b0;
            o_stall_12 = 1'b1;
            o_flush_23 = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_wait_cnt  <= 8'd0;
            r_mem_err   <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_wait_cnt <= (r_state == StWait) ? r_wait_cnt + 8'd1 : 8'd0;
            if (w_timeout) r_mem_err <= 1'b1;
            if (!o_pc_en && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (w_flush_evt && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign o_mem_err   = r_mem_err;
    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;

endmodule
